// File: rtl/timer_pkg.sv
// Shared definitions for the pattern-detect/timer block.
// Holds default sizing for the delay field and prescaler, plus the state
// encoding used by the control FSM that drives timer_datapath.
package timer_pkg;

  localparam int DELAY_W_DEF        = 4;
  localparam int TICKS_PER_UNIT_DEF = 1000;
  localparam int PRESC_W            = $clog2(TICKS_PER_UNIT_DEF);

  // Control FSM states; the datapath only sees the strobes derived from them.
  typedef enum logic [2:0] {
    S_SEARCH,
    S_SHIFT,
    S_COUNT,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/timer_datapath_prescaler.sv
// unit_prescaler: mod-TICKS_PER_UNIT cycle counter.
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   clr           clear to 0 (wins over en)
//   en            advance one tick
//   terminal      en & (cnt == TICKS_PER_UNIT-1): this tick wraps
//   cnt           current prescaler value
module unit_prescaler
  import timer_pkg::*;
#(
  parameter int TICKS_PER_UNIT = TICKS_PER_UNIT_DEF,
  parameter int CNT_W          = $clog2(TICKS_PER_UNIT)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  output logic             terminal,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_UNIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt      = cnt_q;
  assign terminal = en & (cnt_q == LAST);

endmodule

// File: rtl/timer_datapath.sv
// timer_datapath: datapath partner of the pattern-detect/timer FSM.
// Shifts a DELAY_W-bit delay in MSB first, then counts
// (delay+1)*TICKS_PER_UNIT cycles and flags the final one.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   data           serial delay bit, sampled while shift_ena=1
//   shift_ena      shift data into the delay register
//   counting       timer running
//   done_counting  final cycle of the count (combinational from state)
//   count          remaining whole units / shift register contents
//   proto_err      sticky: shift_ena and counting high together
module timer_datapath
  import timer_pkg::*;
#(
  parameter int DELAY_W        = DELAY_W_DEF,
  parameter int TICKS_PER_UNIT = TICKS_PER_UNIT_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               data,
  input  logic               shift_ena,
  input  logic               counting,
  output logic               done_counting,
  output logic [DELAY_W-1:0] count,
  output logic               proto_err
);

  localparam int               PW   = $clog2(TICKS_PER_UNIT);
  localparam logic [PW-1:0]    LAST = PW'(TICKS_PER_UNIT - 1);

  logic [DELAY_W-1:0] rem_q, rem_d;
  logic               perr_q, perr_d;
  logic               run;
  logic               unit_wrap;
  logic [PW-1:0]      presc_cnt;

  // Shift wins over counting; any cycle not actively counting clears the
  // prescaler, so an interrupted unit restarts from scratch.
  assign run = counting & ~shift_ena;

  unit_prescaler #(
    .TICKS_PER_UNIT(TICKS_PER_UNIT),
    .CNT_W         (PW)
  ) u_presc (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (~run),
    .en      (run),
    .terminal(unit_wrap),
    .cnt     (presc_cnt)
  );

  always_comb begin
    rem_d  = rem_q;
    perr_d = perr_q | (shift_ena & counting);
    if (shift_ena)
      rem_d = {rem_q[DELAY_W-2:0], data};
    else if (unit_wrap && rem_q != '0)
      rem_d = rem_q - 1'b1;   // saturate at 0: last unit repeats on re-run
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem_q  <= '0;
      perr_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      perr_q <= perr_d;
    end
  end

  assign done_counting = run & (rem_q == '0) & (presc_cnt == LAST);
  assign count         = rem_q;
  assign proto_err     = perr_q;

endmodule
